fetch_stage: RTL

Instruction-fetch stage directly upstream of the decode/control unit. Holds the PC and drives a request/ready instruction-memory port. Registers each fetched word into an IF/ID register that provides opcode/funct to the control unit. Accepts a stall from decode, and jump / jump-register / taken-branch redirects resolved in decode.

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, request/ready imem port, one-word skid buffer and IF/ID register.
// Optional counters perf_fetched/perf_redirects are built when FETCH_PERF_COUNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        jump_return,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;

    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        slot_free;
    logic        deliver;
    logic [31:0] pc_plus4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        if_valid_d   = if_valid_q;
        deliver      = 1'b0;

        pc_plus4     = pc_q + 32'd4;
        redirect     = if_valid_q && (jump_return || jump || branch_taken);
        redirect_tgt = jump_return ? jr_target :
                       jump        ? {if_pc4_q[31:28], if_instr_q[25:0], 2'b00} :
                                     branch_target;
        slot_free    = !if_valid_q || !id_stall;

        // A redirect always squashes whatever sits in IF/ID.
        if (redirect) begin
            if_instr_d = 32'h0;
            if_valid_d = 1'b0;
        end

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d = redirect_tgt;
                    end else begin
                        tgt_d   = redirect_tgt;
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (slot_free) begin
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc_plus4;
                        if_valid_d = 1'b1;
                        deliver    = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = HOLD;
                    end
                end else if (slot_free) begin
                    if_instr_d = 32'h0;
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!id_stall) begin
                    if_instr_d = skid_instr_q;
                    if_pc4_d   = skid_pc4_q;
                    if_valid_d = 1'b1;
                    deliver    = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                // The outstanding request must complete; its data is thrown away.
                if (redirect) begin
                    tgt_d = redirect_tgt;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_tgt : tgt_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            if_instr_q   <= 32'h0;
            if_pc4_q     <= 32'h0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            if_valid_q   <= if_valid_d;
        end
    end

    assign imem_req    = !reset && (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_pc4   = if_pc4_q;
    assign if_id_valid = if_valid_q;
    assign opcode      = if_instr_q[31:26];
    assign funct       = if_instr_q[5:0];

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] perf_fetched_q, perf_redirects_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q   <= 32'h0;
            perf_redirects_q <= 32'h0;
        end else begin
            if (deliver) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule
